// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter: data port has fixed priority over instruction fetch.
// Optional fetch flush support is compiled in with `define MEMARB_FLUSH_EN.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        stallreq_if_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_mem_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i
`ifdef MEMARB_FLUSH_EN
  ,
  input  logic        flush_i
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_IF,
    BUSY_MEM,
    DONE_IF,
    DONE_MEM
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       grant_if;
  logic       grant_mem;
  logic       flush;

`ifdef MEMARB_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // A requester still holding ce in its DONE cycle is not stalled and is not regranted.
  assign stallreq_if_o  = !rst && if_ce_i  && (state != DONE_IF);
  assign stallreq_mem_o = !rst && mem_ce_i && (state != DONE_MEM);

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    case (state)
      IDLE: begin
        if (mem_ce_i) begin
          state_nxt = BUSY_MEM;
          grant_mem = 1'b1;
        end else if (if_ce_i && !flush) begin
          state_nxt = BUSY_IF;
          grant_if  = 1'b1;
        end
      end
      BUSY_IF: begin
        if (flush)
          state_nxt = IDLE;
        else if (cnt == 4'd0)
          state_nxt = DONE_IF;
      end
      BUSY_MEM: begin
        if (cnt == 4'd0)
          state_nxt = DONE_MEM;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      ram_ce_o   <= 1'b0;
      ram_we_o   <= 1'b0;
      ram_sel_o  <= 4'd0;
      ram_addr_o <= 32'd0;
      ram_data_o <= 32'd0;
      if_data_o  <= 32'd0;
      mem_data_o <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_mem) begin
            ram_ce_o   <= 1'b1;
            ram_we_o   <= mem_we_i;
            ram_sel_o  <= mem_sel_i;
            ram_addr_o <= mem_addr_i;
            ram_data_o <= mem_data_i;
            cnt        <= CNT_INIT;
          end else if (grant_if) begin
            ram_ce_o   <= 1'b1;
            ram_we_o   <= 1'b0;
            ram_sel_o  <= 4'b1111;
            ram_addr_o <= if_addr_i;
            ram_data_o <= 32'd0;
            cnt        <= CNT_INIT;
          end
        end
        BUSY_IF, BUSY_MEM: begin
          if (state == BUSY_IF && flush) begin
            ram_ce_o <= 1'b0;
            ram_we_o <= 1'b0;
          end else if (cnt == 4'd0) begin
            ram_ce_o <= 1'b0;
            ram_we_o <= 1'b0;
            if (state == BUSY_IF)
              if_data_o <= ram_data_i;
            else if (!ram_we_o)
              mem_data_o <= ram_data_i;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          ram_ce_o <= 1'b0;
          ram_we_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal checks plus a
// timestamp-based transaction model compared on every cycle.
module tb_mem_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        stall_if;
  logic        mem_ce;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_data;
  logic        stall_mem;
  logic        ram_ce;
  logic        ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        flush;

  int checks   = 0;
  int failures = 0;
  int issues   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_ce_i       (if_ce),
    .if_addr_i     (if_addr),
    .if_data_o     (if_data),
    .stallreq_if_o (stall_if),
    .mem_ce_i      (mem_ce),
    .mem_we_i      (mem_we),
    .mem_sel_i     (mem_sel),
    .mem_addr_i    (mem_addr),
    .mem_data_i    (mem_wdata),
    .mem_data_o    (mem_data),
    .stallreq_mem_o(stall_mem),
    .ram_ce_o      (ram_ce),
    .ram_we_o      (ram_we),
    .ram_sel_o     (ram_sel),
    .ram_addr_o    (ram_addr),
    .ram_data_o    (ram_wdata),
    .ram_data_i    (ram_rdata)
`ifdef MEMARB_FLUSH_EN
    ,
    .flush_i       (flush)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an access granted at the end of cycle g occupies the bus in
  // cycles g+1..g+W and completes (DONE) in cycle g+W+1.
  int          cyc = 0;
  int          g_start = 0;
  bit          act = 1'b0;
  bit          g_mem = 1'b0;
  bit          started = 1'b0;
  logic        m_we = 1'b0;
  logic [3:0]  m_sel = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_if_data = '0;
  logic [31:0] m_mem_data = '0;
  logic        fl;
  int          ph_u;
  int          ph_c;
  bit          busy;
  bit          done;
  logic        prev_ce = 1'b0;

  always @(posedge clk) begin
`ifdef MEMARB_FLUSH_EN
    fl = flush;
`else
    fl = 1'b0;
`endif
    ph_u = cyc - g_start;
    if (rst) begin
      act = 1'b0; m_we = 1'b0; m_sel = '0; m_addr = '0; m_wdata = '0;
      m_if_data = '0; m_mem_data = '0;
    end else if (act) begin
      if (!g_mem && fl) act = 1'b0;
      else if (ph_u == W) begin
        if (!g_mem) m_if_data = ram_rdata;
        else if (!m_we) m_mem_data = ram_rdata;
      end else if (ph_u == W + 1) act = 1'b0;
    end else if (mem_ce) begin
      act = 1'b1; g_mem = 1'b1; g_start = cyc;
      m_we = mem_we; m_sel = mem_sel; m_addr = mem_addr; m_wdata = mem_wdata;
    end else if (if_ce && !fl) begin
      act = 1'b1; g_mem = 1'b0; g_start = cyc;
      m_we = 1'b0; m_sel = 4'hF; m_addr = if_addr; m_wdata = '0;
    end
    cyc++;
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      ph_c = cyc - g_start;
      busy = act && ph_c >= 1 && ph_c <= W;
      done = act && ph_c == W + 1;
      chk("m_ram_ce",   {31'd0, ram_ce}, {31'd0, busy});
      chk("m_ram_we",   {31'd0, ram_we}, {31'd0, busy && m_we});
      chk("m_ram_sel",  {28'd0, ram_sel}, {28'd0, m_sel});
      chk("m_ram_addr", ram_addr, m_addr);
      chk("m_ram_data", ram_wdata, m_wdata);
      chk("m_if_data",  if_data, m_if_data);
      chk("m_mem_data", mem_data, m_mem_data);
      chk("m_stall_if",  {31'd0, stall_if},
          {31'd0, !rst && if_ce && !(done && !g_mem)});
      chk("m_stall_mem", {31'd0, stall_mem},
          {31'd0, !rst && mem_ce && !(done && g_mem)});
      if (ram_ce && !prev_ce) issues++;
      prev_ce = ram_ce;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  int n0;

  initial begin
    rst = 1'b1; if_ce = 1'b1; if_addr = 32'h0; mem_ce = 1'b1; mem_we = 1'b0;
    mem_sel = 4'hF; mem_addr = 32'h0; mem_wdata = 32'h0; ram_rdata = 32'h0; flush = 1'b0;
    step(); mid();
    chk("rst_stall_if", {31'd0, stall_if}, 32'd0);
    chk("rst_stall_mem", {31'd0, stall_mem}, 32'd0);
    chk("rst_ram_ce", {31'd0, ram_ce}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_mem_data", mem_data, 32'd0);
    if_ce = 1'b0; mem_ce = 1'b0;
    step(); rst = 1'b0;
    step();

    // Load alone
    step(); mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h100;
    mid(); chk("ld_stall_c0", {31'd0, stall_mem}, 32'd1);
    step(); mid(); chk("ld_ce_c1", {31'd0, ram_ce}, 32'd1); chk("ld_addr_c1", ram_addr, 32'h100);
    step(); ram_rdata = 32'hDEADBEEF; mid(); chk("ld_ce_c2", {31'd0, ram_ce}, 32'd1);
    step(); ram_rdata = 32'h0; mid();
    chk("ld_data_c3", mem_data, 32'hDEADBEEF);
    chk("ld_stall_c3", {31'd0, stall_mem}, 32'd0);
    chk("ld_ce_c3", {31'd0, ram_ce}, 32'd0);
    mem_ce = 1'b0;
    step();

    // Store
    step(); mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h200; mem_wdata = 32'h0000ABCD;
    step(); mid();
    chk("st_we_c1", {31'd0, ram_we}, 32'd1);
    chk("st_sel_c1", {28'd0, ram_sel}, 32'h3);
    chk("st_data_c1", ram_wdata, 32'h0000ABCD);
    step(); ram_rdata = 32'h12345678; mid(); chk("st_we_c2", {31'd0, ram_we}, 32'd1);
    step(); ram_rdata = 32'h0; mid();
    chk("st_we_c3", {31'd0, ram_we}, 32'd0);
    chk("st_memdata_c3", mem_data, 32'hDEADBEEF);
    mem_ce = 1'b0; mem_we = 1'b0;
    step();

    // Contention
    step(); if_ce = 1'b1; if_addr = 32'h40; mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h300;
    mid(); chk("ct_stall_if_c0", {31'd0, stall_if}, 32'd1);
    step(); mid(); chk("ct_addr_c1", ram_addr, 32'h300);
    step(); ram_rdata = 32'h11112222;
    step(); ram_rdata = 32'h0; mid();
    chk("ct_stall_mem_c3", {31'd0, stall_mem}, 32'd0);
    chk("ct_stall_if_c3", {31'd0, stall_if}, 32'd1);
    chk("ct_memdata_c3", mem_data, 32'h11112222);
    mem_ce = 1'b0;
    step(); mid(); chk("ct_ce_c4", {31'd0, ram_ce}, 32'd0);
    step(); mid(); chk("ct_ce_c5", {31'd0, ram_ce}, 32'd1); chk("ct_addr_c5", ram_addr, 32'h40);
    step(); ram_rdata = 32'hCAFEF00D;
    step(); ram_rdata = 32'h0; mid();
    chk("ct_stall_if_c7", {31'd0, stall_if}, 32'd0);
    chk("ct_ifdata_c7", if_data, 32'hCAFEF00D);
    if_ce = 1'b0;
    step();

    // Back-to-back fetches
    n0 = issues;
    step(); if_ce = 1'b1; if_addr = 32'h0;
    step();
    step(); ram_rdata = 32'hAAAA0000;
    step(); ram_rdata = 32'h0; mid();
    chk("bb_ifdata_c3", if_data, 32'hAAAA0000);
    if_addr = 32'h4;
    step(); mid(); chk("bb_ce_c4", {31'd0, ram_ce}, 32'd0);
    step(); mid(); chk("bb_addr_c5", ram_addr, 32'h4);
    step(); ram_rdata = 32'hBBBB0004;
    step(); ram_rdata = 32'h0; mid();
    chk("bb_ifdata_c7", if_data, 32'hBBBB0004);
    if_ce = 1'b0;
    step(); step();
    chk("bb_issues", issues - n0, 32'd2);

    // Reset in the middle of a store
    step(); mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'hF; mem_addr = 32'h500; mem_wdata = 32'h55;
    step(); mid(); chk("rs_we_c1", {31'd0, ram_we}, 32'd1);
    step(); rst = 1'b1; mid(); chk("rs_stall_c2", {31'd0, stall_mem}, 32'd0);
    step(); rst = 1'b0; mem_ce = 1'b0; mem_we = 1'b0; mid();
    chk("rs_ce_c3", {31'd0, ram_ce}, 32'd0);
    chk("rs_we_c3", {31'd0, ram_we}, 32'd0);
    chk("rs_stall_mem_c3", {31'd0, stall_mem}, 32'd0);
    chk("rs_stall_if_c3", {31'd0, stall_if}, 32'd0);
    if_ce = 1'b1; if_addr = 32'h80;
    step(); mid(); chk("rs_ce_c4", {31'd0, ram_ce}, 32'd1); chk("rs_addr_c4", ram_addr, 32'h80);
    step(); ram_rdata = 32'h0BADF00D;
    step(); ram_rdata = 32'h0; mid(); chk("rs_ifdata_c6", if_data, 32'h0BADF00D);
    if_ce = 1'b0;
    step();

`ifdef MEMARB_FLUSH_EN
    // Flush during a fetch
    step(); if_ce = 1'b1; if_addr = 32'hC0;
    step(); flush = 1'b1; mid(); chk("fl_ce_c1", {31'd0, ram_ce}, 32'd1);
    step(); flush = 1'b0; if_ce = 1'b0; ram_rdata = 32'hFFFFFFFF; mid();
    chk("fl_ce_c2", {31'd0, ram_ce}, 32'd0);
    chk("fl_ifdata_c2", if_data, 32'h0BADF00D);
    step(); ram_rdata = 32'h0; mid(); chk("fl_ce_c3", {31'd0, ram_ce}, 32'd0);
    // Flush in IDLE suppresses the fetch grant for that cycle only
    step(); if_ce = 1'b1; if_addr = 32'hD0; flush = 1'b1;
    step(); flush = 1'b0; mid(); chk("fi_ce_c1", {31'd0, ram_ce}, 32'd0);
    step(); mid(); chk("fi_ce_c2", {31'd0, ram_ce}, 32'd1);
    step(); ram_rdata = 32'h0D0D0D0D;
    step(); ram_rdata = 32'h0; mid(); chk("fi_ifdata", if_data, 32'h0D0D0D0D);
    if_ce = 1'b0;
    step();
`endif

    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
